// File: rtl/mac_pkg.sv
// Shared definitions for the MAC receive queue arbiter.
// Descriptor layout, FSM encoding and the skid-buffer beat format.
package mac_pkg;

  localparam int DESC_ERR    = 15;
  localparam int DESC_PTP    = 14;
  localparam int LEN_MSB     = 11;
  localparam int LEN_LSB     = 0;
  localparam int LEN_W       = LEN_MSB - LEN_LSB + 1;
  localparam int MTU_DEFAULT = 1500;
  localparam int BEAT_W      = 11;

  typedef enum logic [2:0] {
    IDLE,
    DESC,
    LOAD,
    XFER,
    DROP
  } state_t;

  typedef struct packed {
    logic       tte;
    logic       eop;
    logic       sop;
    logic [7:0] data;
  } beat_t;

  function automatic logic [LEN_W-1:0] desc_len(
    input logic [15:0] d
  );
    return d[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/mac_skid2.sv
// Two-entry valid/ready buffer between the byte FIFOs and the output.
// Head entry stays put while the consumer stalls.
module mac_skid2
  import mac_pkg::*;
#(
  parameter int W = BEAT_W
) (
  input  logic         clk_sys,
  input  logic         rst_sys,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem0;
  logic [W-1:0] mem1;
  logic         wp;
  logic         rp;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = rp ? mem1 : mem0;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      mem0  <= '0;
      mem1  <= '0;
      wp    <= 1'b0;
      rp    <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) begin
        if (wp) mem1 <= in_data;
        else    mem0 <= in_data;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/mac_rx_queue_arb.sv
// Arbitrates normal and TTE receive queues into one byte stream,
// dropping bad frames while keeping byte FIFOs aligned.
module mac_rx_queue_arb
  import mac_pkg::*;
#(
  parameter int MTU           = MTU_DEFAULT,
  parameter int TTE_BURST_MAX = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys,
  input  logic        ptr_fifo_empty,
  input  logic [15:0] ptr_fifo_dout,
  output logic        ptr_fifo_rd,
  input  logic [7:0]  data_fifo_dout,
  output logic        data_fifo_rd,
  input  logic        tteptr_fifo_empty,
  input  logic [15:0] tteptr_fifo_dout,
  output logic        tteptr_fifo_rd,
  input  logic [7:0]  tte_fifo_dout,
  output logic        tte_fifo_rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sop,
  output logic        out_eop,
  output logic        out_tte,
  output logic [15:0] drop_cnt
);

  localparam logic [7:0] RUN_MAX = 8'(TTE_BURST_MAX);
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state;
  state_t           nxt;
  logic             sel_tte;
  logic [LEN_W-1:0] rem;
  logic             first;
  logic [7:0]       tte_run;
  logic [15:0]      drop_q;
  logic             push_d;
  logic             tte_d;
  logic             sop_d;
  logic             eop_d;
  logic             grant_t;
  logic             grant_n;
  logic             byte_rd;
  logic [15:0]      desc;
  logic [LEN_W-1:0] len;
  logic             bad;
  logic             room;
  logic             pop;
  logic             skid_valid;
  logic             skid_in_ready;
  logic [1:0]       occ;
  beat_t            in_beat;
  beat_t            head;
  logic             unused_sig;

  assign desc = sel_tte ? tteptr_fifo_dout : ptr_fifo_dout;
  assign len  = desc_len(desc);
  assign bad  = desc[DESC_ERR] | (len == '0) | (32'(len) > 32'(MTU));
  assign unused_sig = ^{desc[DESC_PTP], desc[13:12], skid_in_ready};

  assign pop  = skid_valid & out_ready;
  // Reads in flight land next cycle, so count them as occupied.
  assign room = (({1'b0, occ} + {2'b0, push_d}) < 3'd2)
              | (pop & (occ == 2'd2) & ~push_d);

  always_comb begin
    nxt     = state;
    grant_t = 1'b0;
    grant_n = 1'b0;
    byte_rd = 1'b0;
    unique case (state)
      IDLE: begin
        if (!tteptr_fifo_empty &&
            !(!ptr_fifo_empty && tte_run == RUN_MAX)) begin
          grant_t = 1'b1;
          nxt     = DESC;
        end else if (!ptr_fifo_empty) begin
          grant_n = 1'b1;
          nxt     = DESC;
        end
      end
      DESC: nxt = LOAD;
      LOAD: nxt = bad ? DROP : XFER;
      XFER: begin
        if (room) begin
          byte_rd = 1'b1;
          if (rem == ONE) nxt = IDLE;
        end
      end
      DROP: begin
        byte_rd = (rem != '0);
        if (rem <= ONE) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (rst_sys) begin
      state   <= IDLE;
      sel_tte <= 1'b0;
      rem     <= '0;
      first   <= 1'b0;
      tte_run <= '0;
      drop_q  <= '0;
      push_d  <= 1'b0;
      tte_d   <= 1'b0;
      sop_d   <= 1'b0;
      eop_d   <= 1'b0;
    end else begin
      state <= nxt;
      if (grant_t)      sel_tte <= 1'b1;
      else if (grant_n) sel_tte <= 1'b0;
      if (grant_t && !ptr_fifo_empty) begin
        if (tte_run != RUN_MAX) tte_run <= tte_run + 8'd1;
      end else if (grant_n || ptr_fifo_empty) begin
        tte_run <= '0;
      end
      if (state == LOAD) begin
        rem   <= len;
        first <= 1'b1;
      end else if (byte_rd) begin
        rem   <= rem - ONE;
        first <= 1'b0;
      end
      // Flags travel with the read so they meet the byte a cycle later.
      push_d <= byte_rd & (state == XFER);
      tte_d  <= sel_tte;
      sop_d  <= first;
      eop_d  <= (rem == ONE);
      if (state == DROP && rem <= ONE && drop_q != 16'hFFFF)
        drop_q <= drop_q + 16'd1;
    end
  end

  assign in_beat.tte  = tte_d;
  assign in_beat.eop  = eop_d;
  assign in_beat.sop  = sop_d;
  assign in_beat.data = tte_d ? tte_fifo_dout : data_fifo_dout;

  mac_skid2 #(.W(BEAT_W)) u_skid (
    .clk_sys   (clk_sys),
    .rst_sys   (rst_sys),
    .in_valid  (push_d),
    .in_ready  (skid_in_ready),
    .in_data   (in_beat),
    .out_valid (skid_valid),
    .out_ready (out_ready),
    .out_data  (head),
    .count     (occ)
  );

  assign ptr_fifo_rd    = grant_n & ~rst_sys;
  assign tteptr_fifo_rd = grant_t & ~rst_sys;
  assign data_fifo_rd   = byte_rd & ~sel_tte & ~rst_sys;
  assign tte_fifo_rd    = byte_rd & sel_tte & ~rst_sys;

  assign out_valid = skid_valid & ~rst_sys;
  assign out_data  = out_valid ? head.data : 8'd0;
  assign out_sop   = out_valid & head.sop;
  assign out_eop   = out_valid & head.eop;
  assign out_tte   = out_valid & head.tte;
  assign drop_cnt  = rst_sys ? 16'd0 : drop_q;

endmodule

// File: tb/tb_mac_rx_queue_arb.sv
// Queue-level reference model and FIFO models driving the arbiter;
// every accepted beat is compared against the model stream.
module tb_mac_rx_queue_arb;
  import mac_pkg::*;

  localparam int MTU = 1500;
  localparam int BURST = 4;

  logic        clk_sys = 1'b0;
  logic        rst_sys = 1'b1;
  logic        ptr_fifo_empty = 1'b1;
  logic [15:0] ptr_fifo_dout = '0;
  logic        ptr_fifo_rd;
  logic [7:0]  data_fifo_dout = '0;
  logic        data_fifo_rd;
  logic        tteptr_fifo_empty = 1'b1;
  logic [15:0] tteptr_fifo_dout = '0;
  logic        tteptr_fifo_rd;
  logic [7:0]  tte_fifo_dout = '0;
  logic        tte_fifo_rd;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_sop;
  logic        out_eop;
  logic        out_tte;
  logic [15:0] drop_cnt;

  mac_rx_queue_arb #(.MTU(MTU), .TTE_BURST_MAX(BURST)) u_dut (
    .clk_sys           (clk_sys),
    .rst_sys           (rst_sys),
    .ptr_fifo_empty    (ptr_fifo_empty),
    .ptr_fifo_dout     (ptr_fifo_dout),
    .ptr_fifo_rd       (ptr_fifo_rd),
    .data_fifo_dout    (data_fifo_dout),
    .data_fifo_rd      (data_fifo_rd),
    .tteptr_fifo_empty (tteptr_fifo_empty),
    .tteptr_fifo_dout  (tteptr_fifo_dout),
    .tteptr_fifo_rd    (tteptr_fifo_rd),
    .tte_fifo_dout     (tte_fifo_dout),
    .tte_fifo_rd       (tte_fifo_rd),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_sop           (out_sop),
    .out_eop           (out_eop),
    .out_tte           (out_tte),
    .drop_cnt          (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  logic [15:0] nd_q[$];
  logic [15:0] td_q[$];
  logic [7:0]  nb_q[$];
  logic [7:0]  tb_q[$];
  logic [10:0] exp_q[$];
  int          vectors = 0;
  int          errors = 0;
  int          exp_drop;
  int          beat_cnt;
  int          neop;
  logic [7:0]  gseq;
  logic [3:0]  rd_s = '0;
  int          rmode = 0;
  int          cyc = 0;
  int          lowcnt = 0;
  bit          low_done = 0;
  bit          stalled = 0;
  logic [10:0] held = '0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // FIFO models: read sampled mid-cycle, dout updated at the edge.
  always @(posedge clk_sys) begin
    if (rst_sys) begin
      ptr_fifo_dout    <= '0;
      tteptr_fifo_dout <= '0;
      data_fifo_dout   <= '0;
      tte_fifo_dout    <= '0;
    end else begin
      if (rd_s[3]) begin
        if (nd_q.size() == 0) chk("ptr_underrun", 32'd1, 32'd0);
        else ptr_fifo_dout <= nd_q.pop_front();
      end
      if (rd_s[2]) begin
        if (nb_q.size() == 0) chk("data_underrun", 32'd1, 32'd0);
        else data_fifo_dout <= nb_q.pop_front();
      end
      if (rd_s[1]) begin
        if (td_q.size() == 0) chk("tteptr_underrun", 32'd1, 32'd0);
        else tteptr_fifo_dout <= td_q.pop_front();
      end
      if (rd_s[0]) begin
        if (tb_q.size() == 0) chk("tte_underrun", 32'd1, 32'd0);
        else tte_fifo_dout <= tb_q.pop_front();
      end
    end
    ptr_fifo_empty    <= (nd_q.size() == 0);
    tteptr_fifo_empty <= (td_q.size() == 0);
  end

  always @(negedge clk_sys) begin
    rd_s = {ptr_fifo_rd, data_fifo_rd, tteptr_fifo_rd, tte_fifo_rd};
    if (!rst_sys) begin
      if (|rd_s) chk("rd_onehot", 32'($countones(rd_s)), 32'd1);
      if (out_valid) chk("skid_occ", 32'(u_dut.u_skid.count <= 2'd2), 32'd1);
      if (stalled)
        chk("stall_hold", {20'd0, out_valid, out_tte, out_eop, out_sop, out_data},
            {20'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (out_eop) neop++;
        if (out_sop) gseq = {gseq[6:0], out_tte};
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else chk("beat", {21'd0, out_tte, out_eop, out_sop, out_data},
                 {21'd0, exp_q.pop_front()});
      end
      stalled = out_valid && !out_ready;
      held    = {out_tte, out_eop, out_sop, out_data};
    end else begin
      stalled = 0;
    end
  end

  always @(posedge clk_sys) begin
    #1;
    cyc++;
    if (rmode == 0) out_ready = 1'b1;
    else if (rmode == 1) out_ready = (cyc % 2 == 0);
    else if (rmode == 2) out_ready = ($urandom_range(9) < 7);
    else begin
      if (!low_done && beat_cnt >= 40) begin
        lowcnt   = 10;
        low_done = 1;
      end
      if (lowcnt > 0) begin
        out_ready = 1'b0;
        lowcnt--;
      end else out_ready = (cyc % 2 == 0);
    end
  end

  function automatic logic [31:0] outs();
    return {ptr_fifo_rd, data_fifo_rd, tteptr_fifo_rd, tte_fifo_rd,
            out_valid, out_sop, out_eop, out_tte, out_data, drop_cnt};
  endfunction

  // Reference: queue counts plus burst rule give the grant order.
  task automatic build_expect();
    logic [7:0] nb[$];
    logic [7:0] tbb[$];
    int it = 0;
    int in_ = 0;
    int run = 0;
    nb  = nb_q;
    tbb = tb_q;
    exp_drop = 0;
    exp_q.delete();
    while (it < td_q.size() || in_ < nd_q.size()) begin
      bit t;
      logic [15:0] d;
      int len;
      bit bad;
      t = (it < td_q.size()) && !((in_ < nd_q.size()) && run == BURST);
      if (t) begin
        d = td_q[it];
        it++;
        run = (in_ < nd_q.size()) ? ((run < BURST) ? run + 1 : run) : 0;
      end else begin
        d = nd_q[in_];
        in_++;
        run = 0;
      end
      len = int'(d[11:0]);
      bad = d[15] || len == 0 || len > MTU;
      for (int i = 0; i < len; i++) begin
        logic [7:0] b;
        b = t ? tbb.pop_front() : nb.pop_front();
        if (!bad) exp_q.push_back({t, i == len - 1, i == 0, b});
      end
      if (bad) exp_drop++;
    end
  endtask

  task automatic add(bit t, logic [15:0] d);
    int len;
    len = int'(d[11:0]);
    if (t) td_q.push_back(d);
    else nd_q.push_back(d);
    for (int i = 0; i < len; i++) begin
      if (t) tb_q.push_back(8'($urandom));
      else nb_q.push_back(8'($urandom));
    end
  endtask

  task automatic scn_begin(int mode);
    @(negedge clk_sys);
    rst_sys = 1'b1;
    nd_q.delete();
    td_q.delete();
    nb_q.delete();
    tb_q.delete();
    exp_q.delete();
    rmode    = mode;
    low_done = 0;
    lowcnt   = 0;
    beat_cnt = 0;
    neop     = 0;
    gseq     = '0;
    @(posedge clk_sys);
    #1;
    chk("reset_outputs", outs(), 32'd0);
  endtask

  task automatic scn_release();
    build_expect();
    repeat (2) @(negedge clk_sys);
    rst_sys = 1'b0;
  endtask

  task automatic scn_finish(string tag, int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk_sys);
      if (exp_q.size() == 0 && nd_q.size() == 0 && td_q.size() == 0 &&
          nb_q.size() == 0 && tb_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    repeat (10) @(negedge clk_sys);
    chk({tag, "_drop"}, {16'd0, drop_cnt}, 32'(exp_drop));
    chk({tag, "_left"}, 32'(exp_q.size() + nb_q.size() + tb_q.size()), 32'd0);
  endtask

  function automatic logic [15:0] mk(bit err, int len);
    return {err, 1'($urandom), 2'b00, 12'(len)};
  endfunction

  initial begin
    // Single 64-byte normal frame.
    scn_begin(0);
    add(0, mk(0, 64));
    scn_release();
    scn_finish("l64", 2000);
    chk("l64_beats", 32'(beat_cnt), 32'd64);

    // Burst limit: six TTE and two normal frames queued together.
    scn_begin(0);
    for (int i = 0; i < 6; i++) add(1, mk(0, 3 + i));
    for (int i = 0; i < 2; i++) add(0, mk(0, 5));
    scn_release();
    scn_finish("grant", 2000);
    chk("grant_order", {24'd0, gseq}, {24'd0, 8'b11110110});

    // Error descriptor then a good frame.
    scn_begin(0);
    add(0, 16'h8040);
    add(0, mk(0, 60));
    scn_release();
    scn_finish("errdrop", 2000);
    chk("errdrop_beats", 32'(beat_cnt), 32'd60);

    // One-byte frame then an oversized descriptor.
    scn_begin(0);
    add(0, mk(0, 1));
    add(0, 16'h07D0);
    scn_release();
    scn_finish("mtu", 5000);
    chk("mtu_beats", 32'(beat_cnt), 32'd1);

    // Toggled ready with a long stall mid-frame.
    scn_begin(3);
    add(0, mk(0, 200));
    add(1, mk(0, 80));
    scn_release();
    scn_finish("stall", 5000);

    // Randomized mixes under several ready patterns.
    for (int s = 0; s < 4; s++) begin
      scn_begin((s == 0) ? 1 : 2);
      for (int f = 0; f < 12; f++) begin
        int r;
        int len;
        r   = $urandom_range(19);
        len = (r == 0) ? 0 : $urandom_range(60, 1);
        add(1'($urandom), mk(r == 1, len));
      end
      scn_release();
      scn_finish("rand", 10000);
    end

    // Reset in the middle of a 100-byte frame.
    scn_begin(0);
    add(0, mk(0, 100));
    scn_release();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk_sys);
      #1;
      if (beat_cnt >= 30) break;
    end
    chk("midrst_reach", 32'(beat_cnt >= 30), 32'd1);
    rst_sys = 1'b1;
    nd_q.delete();
    nb_q.delete();
    exp_q.delete();
    @(posedge clk_sys);
    #1;
    chk("midrst_outputs", outs(), 32'd0);
    chk("midrst_state", 32'(u_dut.state), 32'(IDLE));
    @(negedge clk_sys);
    rst_sys = 1'b0;
    @(posedge clk_sys);
    #1;
    chk("midrst_after", outs(), 32'd0);
    repeat (5) @(negedge clk_sys);
    chk("midrst_no_eop", 32'(neop), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
